// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - valid/ready pipelined adder, one WIDTH/STAGES-bit chunk per stage
// Optional signed-overflow output ovf is built when PIPELINED_ADDER_OVF_EN is defined.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
    ,output logic            ovf
`endif
);

    localparam int CW = WIDTH / STAGES;

    logic              rdy_en;
    logic              vld [STAGES];
    logic [STAGES-1:0] vld_v;
    logic [STAGES-1:0] load;
    logic              acc;

    // up_*[k] is the transaction presented to stage k: operands, partial sum, carry in
    logic [WIDTH-1:0]  up_a [STAGES];
    logic [WIDTH-1:0]  up_b [STAGES];
    logic [WIDTH-1:0]  up_s [STAGES];
    logic              up_c [STAGES];

    // Keeps in_ready low during reset and until the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_comb begin
        vld_v = '0;
        for (int k = 0; k < STAGES; k++) begin
            vld_v[k] = vld[k];
        end
    end

    assign in_ready  = rdy_en && load[0];
    assign acc       = in_valid && in_ready;
    assign out_valid = vld[STAGES-1];

    assign up_a[0] = a;
    assign up_b[0] = b;
    assign up_s[0] = '0;
    assign up_c[0] = cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW:0]      t;
        logic [WIDTH-1:0] s_n;
        logic             src_v;

        // A stage can load unless it and every stage after it are full and the output stalls
        assign load[k] = !(&vld_v[STAGES-1:k]) || out_ready;

        assign t = {1'b0, up_a[k][k*CW +: CW]} + {1'b0, up_b[k][k*CW +: CW]}
                 + {{CW{1'b0}}, up_c[k]};

        always_comb begin
            s_n              = up_s[k];
            s_n[k*CW +: CW]  = t[CW-1:0];
        end

        if (k == 0) begin : g_src_in
            assign src_v = acc;
        end else begin : g_src_prev
            assign src_v = vld[k-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld[k] <= 1'b0;
            end else if (load[k]) begin
                vld[k] <= src_v;
            end
        end

        if (k < STAGES-1) begin : g_mid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    up_a[k+1] <= '0;
                    up_b[k+1] <= '0;
                    up_s[k+1] <= '0;
                    up_c[k+1] <= 1'b0;
                end else if (load[k] && src_v) begin
                    up_a[k+1] <= up_a[k];
                    up_b[k+1] <= up_b[k];
                    up_s[k+1] <= s_n;
                    up_c[k+1] <= t[CW];
                end
            end
        end else begin : g_last
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum  <= '0;
                    cout <= 1'b0;
`ifdef PIPELINED_ADDER_OVF_EN
                    ovf  <= 1'b0;
`endif
                end else if (load[k] && src_v) begin
                    sum  <= s_n;
                    cout <= t[CW];
`ifdef PIPELINED_ADDER_OVF_EN
                    ovf  <= (up_a[k][WIDTH-1] == up_b[k][WIDTH-1])
                         && (s_n[WIDTH-1] != up_a[k][WIDTH-1]);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder (8/2 and 16/4 instances)
module tb_pipelined_adder;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int W2 = 16;
    localparam int S2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [W-1:0]  a, b, sum;
    logic          in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2;
    logic [W2-1:0] a2, b2, sum2;
`ifdef PIPELINED_ADDER_OVF_EN
    logic          ovf, ovf2;
`endif

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef PIPELINED_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipelined_adder #(.WIDTH(W2), .STAGES(S2)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2)
`ifdef PIPELINED_ADDER_OVF_EN
        , .ovf(ovf2)
`endif
    );

    typedef struct {
        logic [63:0] v;
        logic        o;
    } exp_t;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    exp_t q[$];
    exp_t q2[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc_no = 0, n_out = 0, n_in = 0, n_out2 = 0, n_in2 = 0;
    int   first_out = -1, last_out = -1;

    function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv,
                                   input logic c, input int w);
        exp_t   e;
        longint half, sa, sb, r, ci;
        half = longint'(1) << (w - 1);
        ci   = c ? 1 : 0;
        e.v  = av + bv + 64'(ci);
        sa   = (longint'(av) >= half) ? longint'(av) - 2 * half : longint'(av);
        sb   = (longint'(bv) >= half) ? longint'(bv) - 2 * half : longint'(bv);
        r    = sa + sb + ci;
        e.o  = (r >= half) || (r < -half);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock: log transfers into the reference queues, then advance to 1ns past the edge
    task automatic cyc();
        exp_t e;
        #1;
        if (in_valid && in_ready) begin
            q.push_back(model(64'(a), 64'(b), cin, W));
            n_in++;
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("sb_spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                chk("sb_sum", 64'(sum), 64'(e.v[W-1:0]));
                chk("sb_cout", 64'(cout), 64'(e.v[W]));
`ifdef PIPELINED_ADDER_OVF_EN
                chk("sb_ovf", 64'(ovf), 64'(e.o));
`endif
            end
            n_out++;
            if (first_out < 0) first_out = cyc_no;
            last_out = cyc_no;
        end
        if (in_valid2 && in_ready2) begin
            q2.push_back(model(64'(a2), 64'(b2), cin2, W2));
            n_in2++;
        end
        if (out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                chk("sb16_spurious_out", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("sb16_sum", 64'(sum2), 64'(e.v[W2-1:0]));
                chk("sb16_cout", 64'(cout2), 64'(e.v[W2]));
`ifdef PIPELINED_ADDER_OVF_EN
                chk("sb16_ovf", 64'(ovf2), 64'(e.o));
`endif
            end
            n_out2++;
        end
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    vec_t tbl[8];
    int   stalls;
    logic hold, hc;
    logic [W-1:0] hs;

    initial begin
        tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{8'h0F, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0;
        in_valid2 = 0; out_ready2 = 1; a2 = '0; b2 = '0; cin2 = 0;
        @(posedge clk);
        #1;

        // Reset with random activity on the inputs
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            cyc();
            chk("rst_out_valid", 64'(out_valid), 0);
            chk("rst_in_ready", 64'(in_ready), 0);
            chk("rst_sum", 64'(sum), 0);
            chk("rst_cout", 64'(cout), 0);
        end
        in_valid = 0; out_ready = 1;
        rst_n = 1'b1;
        #1;
        chk("rel_ready_before_edge", 64'(in_ready), 0);
        cyc();
        chk("rel_ready_after_edge", 64'(in_ready), 1);

        // Directed vectors, one at a time, with latency check
        foreach (tbl[i]) begin
            a = tbl[i].va; b = tbl[i].vb; cin = tbl[i].vc; in_valid = 1;
            #1;
            chk("tbl_in_ready", 64'(in_ready), 1);
            cyc();
            in_valid = 0;
            repeat (S - 1) begin
                chk("tbl_lat_early", 64'(out_valid), 0);
                cyc();
            end
            chk("tbl_out_valid", 64'(out_valid), 1);
            chk("tbl_sum", 64'(sum), 64'(tbl[i].es));
            chk("tbl_cout", 64'(cout), 64'(tbl[i].ec));
`ifdef PIPELINED_ADDER_OVF_EN
            chk("tbl_ovf", 64'(ovf), 64'(tbl[i].eo));
`endif
            cyc();
        end

        // 256 back-to-back transactions with the output always ready
        stalls = 0; n_out = 0; first_out = -1; last_out = -1;
        for (int i = 0; i < 256; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1;
            #1;
            if (!in_ready) stalls++;
            cyc();
        end
        in_valid = 0;
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
        chk("stream_stalls", 64'(stalls), 0);
        chk("stream_count", 64'(n_out), 256);
        chk("stream_no_bubble", 64'(last_out - first_out), 255);
        chk("stream_drained", 64'(q.size()), 0);

        // Backpressure: STAGES accepted, next one waits and enters on the first drain edge
        out_ready = 0; n_out = 0;
        for (int t = 0; t <= S; t++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1;
            #1;
            chk("bp_in_ready", 64'(in_ready), (t < S) ? 1 : 0);
            cyc();
        end
        chk("bp_out_valid", 64'(out_valid), 1);
        chk("bp_first_sum", 64'(sum), 64'(q[0].v[W-1:0]));
        hs = sum; hc = cout;
        repeat (3) begin
            cyc();
            chk("bp_hold_ready", 64'(in_ready), 0);
            chk("bp_hold_sum", 64'(sum), 64'(hs));
            chk("bp_hold_cout", 64'(cout), 64'(hc));
        end
        out_ready = 1;
        #1;
        chk("bp_same_edge_accept", 64'(in_ready), 1);
        cyc();
        in_valid = 0;
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
        chk("bp_count", 64'(n_out), S + 1);
        chk("bp_drained", 64'(q.size()), 0);

        // Reset with two transactions in flight
        for (int t = 0; t < 2; t++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1;
            cyc();
        end
        in_valid = 0;
        rst_n = 0;
        q.delete(); q2.delete();
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 0);
        chk("mid_rst_in_ready", 64'(in_ready), 0);
        cyc();
        rst_n = 1;
        for (int i = 0; i < S + 2; i++) begin
            cyc();
            chk("post_rst_out_valid", 64'(out_valid), 0);
        end

        // Random valid/ready traffic with hold-stability checks
        n_in = 0; n_out = 0;
        for (int i = 0; i < 400; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(4, 0) > 1);
            #1;
            hold = out_valid && !out_ready; hs = sum; hc = cout;
            cyc();
            if (hold) begin
                chk("rnd_hold_valid", 64'(out_valid), 1);
                chk("rnd_hold_sum", 64'(sum), 64'(hs));
                chk("rnd_hold_cout", 64'(cout), 64'(hc));
            end
        end
        in_valid = 0; out_ready = 1;
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
        chk("rnd_drained", 64'(q.size()), 0);
        chk("rnd_in_eq_out", 64'(n_out), 64'(n_in));

        // WIDTH=16, STAGES=4 instance: directed overflow case, latency, then a stream
        a2 = 16'h7FFF; b2 = 16'h0001; cin2 = 0; in_valid2 = 1;
        cyc();
        in_valid2 = 0;
        repeat (S2 - 1) begin
            chk("w16_lat_early", 64'(out_valid2), 0);
            cyc();
        end
        chk("w16_out_valid", 64'(out_valid2), 1);
        chk("w16_sum", 64'(sum2), 64'h8000);
        chk("w16_cout", 64'(cout2), 0);
`ifdef PIPELINED_ADDER_OVF_EN
        chk("w16_ovf", 64'(ovf2), 1);
`endif
        cyc();
        a2 = 16'h8000; b2 = 16'h8000; cin2 = 0; in_valid2 = 1;
        cyc();
        for (int i = 0; i < 64; i++) begin
            a2 = W2'($urandom); b2 = W2'($urandom); cin2 = 1'($urandom); in_valid2 = 1;
            cyc();
        end
        in_valid2 = 0;
        for (int i = 0; i < 20 && q2.size() != 0; i++) cyc();
        chk("w16_drained", 64'(q2.size()), 0);
        chk("w16_in_eq_out", 64'(n_out2), 64'(n_in2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits (1..64).
REQ-002 Parameter STAGES, default 2: pipeline depth; WIDTH SHALL be an integer multiple of STAGES; each stage adds a chunk of WIDTH/STAGES bits.
REQ-003 clk  input  1  single clock; all state rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operands and carry-in presented.
REQ-006 in_ready  output  1  block accepts the input this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned.
REQ-008 b  input  WIDTH  operand B, unsigned.
REQ-009 cin  input  1  carry-in.
REQ-010 out_valid  output  1  result presented.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  signed two's-complement overflow; present only when the configuration macro is defined (see Configuration).

Function
REQ-015 An input transfer occurs on a rising edge where in_valid && in_ready; an output transfer occurs where out_valid && out_ready.
REQ-016 Stage k (0..STAGES-1) SHALL add chunk k of a and b plus the carry from stage k-1 (stage 0 uses cin); chunk 0 holds the LSBs.
REQ-017 Operand bits not yet consumed SHALL be carried forward with the transaction; completed sum chunks SHALL be carried forward with the transaction.
REQ-018 Latency with out_ready held high: out_valid asserts exactly STAGES cycles after the accepting edge.
REQ-019 Throughput with out_ready high: one transaction per cycle, no bubbles.
REQ-020 Each stage has a valid bit; a stage SHALL load when it is empty or when its content moves on in the same cycle.
REQ-021 The last stage SHALL move on only on an output transfer; in_ready = !valid[0] || stage 0 moves on (combinational from out_ready allowed).
REQ-022 With out_ready low, the pipeline SHALL fill and hold; exactly STAGES transactions are buffered before in_ready deasserts; no data is lost or duplicated.
REQ-023 sum, cout (and ovf) SHALL hold stable while out_valid && !out_ready.
REQ-024 A simultaneous output transfer and input transfer at full occupancy SHALL be accepted with no bubble.
REQ-025 Results SHALL emerge in acceptance order.
REQ-026 Wrap-around: a sum of 2^WIDTH or more SHALL appear modulo 2^WIDTH with cout=1.

Reset
REQ-027 While rst_n=0, all stage valid bits SHALL be 0: out_valid=0, in_ready=0, sum=0, cout=0, ovf=0.
REQ-028 Reset mid-operation SHALL discard all in-flight transactions.
REQ-029 in_ready SHALL assert on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro PIPELINED_ADDER_OVF_EN.
- Defined: port ovf exists; ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), computed in the last stage and aligned with sum.
- Undefined: port ovf and its logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-031 Reset: rst_n=0 with random inputs -> out_valid=0, in_ready=0, sum=0x00; release -> in_ready=1 on the next edge.
REQ-032 Carry across chunk: a=0xFF, b=0x01, cin=0, out_ready=1 -> after 2 cycles sum=0x00, cout=1; a=0x0F, b=0x00, cin=1 -> sum=0x10, cout=0.
REQ-033 Streaming: 256 back-to-back random transactions with out_ready=1 -> one result per cycle, in order, each matching a reference model.
REQ-034 Backpressure: out_ready=0; offer 3 transactions -> 2 accepted, in_ready=0, out_valid=1 with the first sum stable; raise out_ready -> both drain in order, third is accepted on the same edge as the first drain.
REQ-035 Reset mid-flight: 2 transactions in flight, pulse rst_n low for 1 cycle -> no out_valid for either transaction afterwards.
REQ-036 PIPELINED_ADDER_OVF_EN defined: a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0; a=0x80, b=0x80 -> sum=0x00, ovf=1, cout=1; repeat with WIDTH=16, STAGES=4.
